// File: rtl/debug_regfile_dump_pkg.sv
// Shared types and helpers for the register-file debug dumper.
// State encodings include CHECKSUM only when DEBUG_DUMP_CHECKSUM_EN is defined.
package debug_regfile_dump_pkg;

    localparam int NB_BYTE_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_SEND     = 3'd3,
`ifdef DEBUG_DUMP_CHECKSUM_EN
        ST_CHECKSUM = 3'd4,
`endif
        ST_DONE     = 3'd5
    } state_t;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

endpackage

// File: rtl/debug_regfile_dump_if.sv
// Bundle of the register-file debug read port and the byte stream to the UART TX.
// The master modport is the dumper side, the slave modport is the regfile/UART side.
interface debug_regfile_dump_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8
);
    logic [NB_REG-1:0]  address_read_debug;
    logic [NB_DATA-1:0] data_read_debug;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        output address_read_debug,
        input  data_read_debug,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  address_read_debug,
        output data_read_debug,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/debug_regfile_dump_serializer.sv
// debug_word_serializer: emits a loaded word MSB-first as bytes over valid/ready.
// A single byte can also be loaded; it is then flagged as the last byte at once.
module debug_word_serializer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_load_byte,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last,
    output logic               o_xfer
);
    localparam int BPW   = NB_DATA / NB_BYTE;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] r_word;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;

    // The current byte always sits in the top slot; the word shifts up on each transfer.
    assign o_tx_data  = r_word[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid = r_valid;
    assign o_xfer     = r_valid & i_tx_ready;
    assign o_last     = (r_idx == IDX_W'(BPW - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (i_load_byte) begin
            r_word  <= {i_byte, {(NB_DATA-NB_BYTE){1'b0}}};
            r_idx   <= IDX_W'(BPW - 1);
            r_valid <= 1'b1;
        end else if (o_xfer) begin
            r_word <= r_word << NB_BYTE;
            if (o_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_regfile_dump.sv
// Walks the register-file debug read port and streams every word MSB-first as bytes.
// Optional trailing XOR checksum byte when DEBUG_DUMP_CHECKSUM_EN is defined.
module debug_regfile_dump
    import debug_regfile_dump_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = NB_BYTE_DEF,
    parameter int N_REGS  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    debug_regfile_dump_if.master bus
);
    localparam int BPW = bytes_per_word(NB_DATA, NB_BYTE);

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_REG-1:0]  r_reg_cnt;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_load;
    logic               w_load_byte;
    logic               w_last_reg;
    logic [NB_BYTE-1:0] w_ser_data;
    logic [NB_BYTE-1:0] w_csum_byte;
    logic               w_ser_valid;
    logic               w_ser_last;
    logic               w_ser_xfer;

    assign w_last_reg = (r_reg_cnt == NB_REG'(N_REGS - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_load       = 1'b0;
        w_load_byte  = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = ST_ADDR;
                end
            end
            // Wait state lets a registered read port settle before the sample.
            ST_ADDR: w_state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                w_load       = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_ser_xfer && w_ser_last) begin
                    if (w_last_reg) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        w_load_byte  = 1'b1;
                        w_state_next = ST_CHECKSUM;
`else
                        w_state_next = ST_DONE;
`endif
                    end else begin
                        w_cnt_inc    = 1'b1;
                        w_state_next = ST_ADDR;
                    end
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (w_ser_xfer) begin
                    w_state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_reg_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_reg_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_reg_cnt <= r_reg_cnt + NB_REG'(1);
        end
    end

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_csum;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_csum <= '0;
        end else if (w_cnt_clr) begin
            r_csum <= '0;
        end else if (w_ser_xfer && (r_state == ST_SEND)) begin
            r_csum <= r_csum ^ w_ser_data;
        end
    end

    // Folds in the final data byte, which transfers on the same edge the checksum loads.
    assign w_csum_byte = r_csum ^ w_ser_data;
`else
    assign w_csum_byte = '0;
`endif

    debug_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_word      (bus.data_read_debug),
        .i_load_byte (w_load_byte),
        .i_byte      (w_csum_byte),
        .i_tx_ready  (bus.tx_ready),
        .o_tx_data   (w_ser_data),
        .o_tx_valid  (w_ser_valid),
        .o_last      (w_ser_last),
        .o_xfer      (w_ser_xfer)
    );

    assign bus.address_read_debug = r_reg_cnt;
    assign bus.tx_data            = w_ser_data;
    assign bus.tx_valid           = w_ser_valid;

endmodule

// File: tb/tb_debug_regfile_dump.sv
// Directed bench for debug_regfile_dump; define DEBUG_DUMP_CHECKSUM_EN to cover the checksum byte.
module tb_debug_regfile_dump;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int NBYTES = 129;
    localparam int DONE_K = 193;
`else
    localparam int NBYTES = 128;
    localparam int DONE_K = 192;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    logic [31:0] regs [32];

    int checks = 0;
    int failures = 0;
    int nbytes;
    int ndone;
    int done_k;
    logic [7:0] first_byte;
    logic [7:0] last_byte;

    debug_regfile_dump_if #(.NB_DATA(32), .NB_REG(5), .NB_BYTE(8)) bus ();

    assign bus.data_read_debug = regs[bus.address_read_debug];

    debug_regfile_dump dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] data_byte(input int n);
        logic [31:0] w;
        w = regs[n / 4] >> (8 * (3 - (n % 4)));
        return w[7:0];
    endfunction

    function automatic logic [7:0] exp_byte(input int n);
        logic [7:0] x;
        x = 8'h00;
        if (n < 128) return data_byte(n);
        for (int i = 0; i < 128; i++) x = x ^ data_byte(i);
        return x;
    endfunction

    // pct: tx_ready duty in percent; stall_at: hold ready low 50 cycles after that many bytes;
    // repulse: re-pulse start at byte 40 and in the DONE cycle; abort_at: assert reset after that many bytes.
    task automatic dump(input int pct, input int stall_at, input bit repulse, input int abort_at);
        int k;
        int stall;
        bit stalled;
        bit seen_done;
        bit fin;
        logic [7:0] hold;
        logic prev_valid;
        logic prev_ready;
        logic [7:0] prev_data;
        nbytes = 0; ndone = 0; done_k = -1; stall = 0; seen_done = 0; fin = 0;
        hold = 8'h00; prev_valid = 0; prev_ready = 0; prev_data = 8'h00;
        first_byte = 8'hxx; last_byte = 8'hxx;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!fin) begin
            if (stall > 0) begin
                bus.tx_ready = 1'b0;
                stall--;
                stalled = 1;
            end else begin
                stalled = 0;
                if (pct >= 100) bus.tx_ready = 1'b1;
                else bus.tx_ready = ($urandom_range(0, 99) < pct);
            end
            #1;
            if (k == 0) begin
                chk("busy_after_start", busy, 1);
                chk("first_address", bus.address_read_debug, 0);
            end
            if (stalled) begin
                chk("stall_valid", bus.tx_valid, 1);
                if (stall == 49) hold = bus.tx_data;
                else chk("stall_data", bus.tx_data, hold);
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", bus.tx_valid, 1);
                chk("hold_data", bus.tx_data, prev_data);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                chk("byte", bus.tx_data, exp_byte(nbytes));
                if (nbytes == 0) first_byte = bus.tx_data;
                last_byte = bus.tx_data;
                nbytes++;
                if (nbytes == stall_at) stall = 50;
                if (repulse && nbytes == 40) start = 1'b1;
                if (abort_at > 0 && nbytes == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    chk("abort_valid", bus.tx_valid, 0);
                    chk("abort_data", bus.tx_data, 0);
                    chk("abort_address", bus.address_read_debug, 0);
                    fin = 1;
                end
            end
            if (!fin) begin
                if (done) begin
                    ndone++;
                    done_k = k;
                    seen_done = 1;
                    if (repulse) start = 1'b1;
                end else if (seen_done && !busy) begin
                    fin = 1;
                end
            end
            if (k > 5000) begin
                chk("timeout", 0, 1);
                fin = 1;
            end
            prev_valid = bus.tx_valid;
            prev_ready = bus.tx_ready;
            prev_data  = bus.tx_data;
            if (!fin) begin
                @(negedge clk);
                start = 1'b0;
                k++;
            end
        end
    endtask

    initial begin
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0A0B0C00 + i;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_address", bus.address_read_debug, 0);
        chk("reset_tx_data", bus.tx_data, 0);
        chk("reset_tx_valid", bus.tx_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        dump(100, 0, 0, 0);
        chk("full_nbytes", nbytes, NBYTES);
        chk("full_ndone", ndone, 1);
        chk("full_done_latency", done_k, DONE_K);
        chk("full_first_byte", first_byte, 8'h0A);
`ifndef DEBUG_DUMP_CHECKSUM_EN
        chk("full_last_byte", last_byte, 8'h1F);
`endif

        dump(30, 0, 0, 0);
        chk("random_nbytes", nbytes, NBYTES);
        chk("random_ndone", ndone, 1);

        dump(100, 10, 0, 0);
        chk("stall_nbytes", nbytes, NBYTES);
        chk("stall_ndone", ndone, 1);

        dump(100, 0, 1, 0);
        chk("repulse_nbytes", nbytes, NBYTES);
        chk("repulse_ndone", ndone, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("repulse_idle", busy, 0);
        chk("repulse_no_valid", bus.tx_valid, 0);

        dump(100, 0, 0, 70);
        chk("abort_nbytes", nbytes, 70);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dump(100, 0, 0, 0);
        chk("restart_first_byte", first_byte, 8'h0A);
        chk("restart_nbytes", nbytes, NBYTES);
        chk("restart_ndone", ndone, 1);

`ifdef DEBUG_DUMP_CHECKSUM_EN
        for (int i = 0; i < 32; i++) regs[i] = i;
        dump(100, 0, 0, 0);
        chk("csum_nbytes", nbytes, 129);
        chk("csum_zero", last_byte, 8'h00);
        regs[5] = 32'h000000FF;
        dump(100, 0, 0, 0);
        chk("csum_fa", last_byte, 8'hFA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
